if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end that consumes the pipeline-control outputs: `stallpc`, `je`/`jump_addr`, `stallif` and `flushif`.
- Owns the PC register and drives a single-outstanding request/response instruction bus.
- Delivers registered {inst, inst_addr, valid} to the ID stage.
- A one-entry holding buffer captures a response that returns while IF is stalled.

Parameters:
- `XLEN`, default 32 (matches `` `XLEN ``): address and data width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stallpc_i`  in  1  hold PC and block new requests
- `je_i`  in  1  jump/branch taken, redirect PC
- `jump_addr_i`  in  XLEN  redirect target
- `stallif_i`  in  1  hold IF/ID output registers
- `flushif_i`  in  1  invalidate IF/ID output and holding buffer
- `ibus_req_o`  out  1  fetch request
- `ibus_addr_o`  out  XLEN  fetch address, bits [1:0] always 0
- `ibus_ready_i`  in  1  request accepted when `req & ready`
- `ibus_rvalid_i`  in  1  response valid
- `ibus_rdata_i`  in  XLEN  instruction word
- `inst_o`  out  XLEN  instruction to ID
- `inst_addr_o`  out  XLEN  PC of `inst_o`
- `inst_valid_o`  out  1  `inst_o` is valid

Behaviour:
- Reset (async, `rst_n` low) takes effect immediately:
  - `pc_q` = `RESET_PC`, `outst_q` = 0, `discard_q` = 0, `buf_v_q` = 0, `inst_valid_o` = 0.
  - `inst_o` = 32'h0000_0013 (NOP); `inst_addr_o` = 0.
  - `ibus_req_o` = 0 while reset is asserted and in the first cycle after release (FSM state `BOOT`).
- FSM states: `BOOT` -> `RUN` unconditionally after one cycle. All fetching happens in `RUN`.
- Issue condition (combinational `ibus_req_o`): `RUN & !je_i & !stallpc_i & !stallif_i & !buf_v_q & (!outst_q | ibus_rvalid_i)`.
- `ibus_addr_o` = {`pc_q`[XLEN-1:2], 2'b00}.
- On accept (`req & ready`):
  - `outst_q` <= 1, `req_addr_q` <= `ibus_addr_o`, `pc_q` <= `pc_q` + 4 (wraps modulo 2^XLEN).
  - `ibus_addr_o` must be held stable while `req` is high and `ready` is low.
- On response (`ibus_rvalid_i & outst_q`): `outst_q` is cleared unless a new accept occurs in the same cycle. A response with `outst_q` = 0 is ignored.
- Redirect (`je_i` = 1):
  - `pc_q` <= {`jump_addr_i`[XLEN-1:2], 2'b00}. Redirect has priority over `stallpc_i` and over the +4 update.
  - If a request is outstanding and its response does not arrive this cycle, set `discard_q`. The next response is dropped and clears `discard_q`.
  - A response arriving in the `je_i` cycle itself is dropped.
- Output/buffer update, in priority order:
  1. `flushif_i`: `inst_valid_o` <= 0, `buf_v_q` <= 0. Any live response this cycle is dropped.
  2. `stallif_i`: outputs hold. A live (non-discarded) response is written to the buffer: `buf_v_q` <= 1.
  3. Otherwise:
     - If `buf_v_q`: output <= buffer, `buf_v_q` <= 0.
     - Else if live response: output <= {`ibus_rdata_i`, `req_addr_q`}, valid = 1.
     - Else `inst_valid_o` <= 0.
- Buffer overflow is impossible by construction: issue is blocked while `buf_v_q` or any stall is set. Assert `buf_v_q & live response` never occurs.
- Latency and throughput:
  - Accept at cycle N with `rvalid` at N+1 gives `inst_valid_o` high at N+2.
  - Back-to-back accepts with 1-cycle memory sustain 1 instruction/cycle.
  - After a stall that buffered a response, expect one bubble cycle (buffer drain blocks issue).
- Simultaneous `je_i` and `stallif_i`/`stallpc_i` (load-use plus branch): the redirect and flush win, and PC takes `jump_addr_i`.
- Bus errors are not modelled.

Test Plan:
1. Reset release, `ready`=1, `rvalid` one cycle after accept with rdata = addr ^ 32'hA5A5_0000 -> first accept at cycle 1 with addr 0; `inst_valid_o` at cycle 3 with `inst_addr_o`=0; then 4, 8, 12 on consecutive cycles.
2. Hold `ready`=0 for 3 cycles on addr 0x10 -> `ibus_addr_o` stable at 0x10; `pc_q` unchanged until accept.
3. Assert `stallif_i`=`stallpc_i`=1 for 2 cycles while addr 0x20 is outstanding -> response goes to the buffer; `inst_o` holds 0x1C's word; no request is issued; on release 0x20 appears, with a one-cycle bubble before 0x24 is requested.
4. `je_i`=1 with `jump_addr_i`=0x103 while 0x40 is outstanding and its response is delayed 2 cycles -> 0x40 response dropped; next request addr 0x100; no valid output with addr 0x40.
5. `je_i`, `flushif_i` and `stallif_i` all high in one cycle with the buffer full -> `inst_valid_o`=0 and `buf_v_q`=0 next cycle; the next fetch is from the jump target.
6. Drop `rst_n` while a request is outstanding -> all outputs return to reset values asynchronously; the stale response after release is ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a single-outstanding
// request/response instruction bus and registers {inst, addr, valid} for ID.
module if_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stallpc_i,
    input  logic            je_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            stallif_i,
    input  logic            flushif_i,
    output logic            ibus_req_o,
    output logic [XLEN-1:0] ibus_addr_o,
    input  logic            ibus_ready_i,
    input  logic            ibus_rvalid_i,
    input  logic [XLEN-1:0] ibus_rdata_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic            inst_valid_o
);

    localparam logic [XLEN-1:0] NOP_INST   = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_outst;
    logic            r_discard;
    logic            r_buf_v;
    logic [XLEN-1:0] r_buf_inst;
    logic [XLEN-1:0] r_buf_addr;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_addr;
    logic            r_inst_valid;

    logic            w_req;
    logic            w_accept;
    logic            w_rsp;
    logic            w_live;
    logic [XLEN-1:0] w_fetch_addr;
    logic [XLEN-1:0] w_jump_tgt;

    // A new request may overlap the cycle in which the previous response returns.
    assign w_req        = (r_state == ST_RUN) & ~je_i & ~stallpc_i & ~stallif_i
                        & ~r_buf_v & (~r_outst | ibus_rvalid_i);
    assign w_accept     = w_req & ibus_ready_i;
    assign w_rsp        = ibus_rvalid_i & r_outst;
    assign w_live       = w_rsp & ~r_discard & ~je_i;
    assign w_fetch_addr = r_pc & ALIGN_MASK;
    assign w_jump_tgt   = jump_addr_i & ALIGN_MASK;

    assign ibus_req_o   = w_req;
    assign ibus_addr_o  = w_fetch_addr;
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;

    // Boot sequencing, PC and outstanding-request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_req_addr <= '0;
            r_outst    <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_state <= ST_RUN;

            if (je_i) begin
                r_pc <= w_jump_tgt;
            end else if (w_accept) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_accept) begin
                r_outst    <= 1'b1;
                r_req_addr <= w_fetch_addr;
            end else if (w_rsp) begin
                r_outst <= 1'b0;
            end

            // The response still in flight at a redirect belongs to the old path.
            if (je_i && r_outst && !ibus_rvalid_i) begin
                r_discard <= 1'b1;
            end else if (w_rsp) begin
                r_discard <= 1'b0;
            end
        end
    end

    // IF/ID output registers and the one-entry stall holding buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_v      <= 1'b0;
            r_buf_inst   <= '0;
            r_buf_addr   <= '0;
            r_inst       <= NOP_INST;
            r_inst_addr  <= '0;
            r_inst_valid <= 1'b0;
        end else if (flushif_i) begin
            r_inst_valid <= 1'b0;
            r_buf_v      <= 1'b0;
        end else if (stallif_i) begin
            if (w_live) begin
                r_buf_v    <= 1'b1;
                r_buf_inst <= ibus_rdata_i;
                r_buf_addr <= r_req_addr;
            end
        end else if (r_buf_v) begin
            r_inst       <= r_buf_inst;
            r_inst_addr  <= r_buf_addr;
            r_inst_valid <= 1'b1;
            r_buf_v      <= 1'b0;
        end else if (w_live) begin
            r_inst       <= ibus_rdata_i;
            r_inst_addr  <= r_req_addr;
            r_inst_valid <= 1'b1;
        end else begin
            r_inst_valid <= 1'b0;
        end
    end

    // Issue is blocked while the buffer is full, so a live response cannot meet it.
    a_no_buf_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(r_buf_v && w_live));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, hand-written corner sequences,
// and a randomized run checked against an instruction-stream reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        stallpc_i;
    logic        je_i;
    logic [31:0] jump_addr_i;
    logic        stallif_i;
    logic        flushif_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ready_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallpc_i    (stallpc_i),
        .je_i         (je_i),
        .jump_addr_i  (jump_addr_i),
        .stallif_i    (stallif_i),
        .flushif_i    (flushif_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_ready_i (ibus_ready_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Behavioural memory: one pending response with a countdown.
    logic        m_act = 1'b0;
    logic [31:0] m_addr = '0;
    int unsigned m_cnt = 0;

    // Samples taken at negedge+1 of each cycle.
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_iaddr;

    typedef struct {
        logic        rdy;
        logic        stl;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] iaddr;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // One cycle: drive inputs after negedge, sample, register any accept, wait.
    task automatic step(input logic rdy, input logic stl, input logic jmp, input logic fl,
                        input logic [31:0] ja, input int unsigned dly);
        if (m_act && m_cnt == 0) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = m_addr ^ KEY;
            m_act         = 1'b0;
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = $urandom;
            if (m_act) m_cnt = m_cnt - 1;
        end
        ibus_ready_i = rdy;
        stallif_i    = stl;
        stallpc_i    = stl;
        je_i         = jmp;
        flushif_i    = fl;
        jump_addr_i  = ja;
        #1;
        s_req   = ibus_req_o;
        s_addr  = ibus_addr_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        if (s_req && rdy) begin
            m_act  = 1'b1;
            m_addr = s_addr;
            m_cnt  = dly;
        end
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic vld, input logic [31:0] ia);
        chk({nm, " valid"}, 32'(s_valid), 32'(vld));
        if (vld) begin
            chk({nm, " inst_addr"}, s_iaddr, ia);
            chk({nm, " inst"}, s_inst, ia ^ KEY);
        end
    endtask

    task automatic chk_req(input string nm, input logic req, input logic [31:0] a);
        chk({nm, " req"}, 32'(s_req), 32'(req));
        if (req) chk({nm, " addr"}, s_addr, a);
    endtask

    // Random-run state
    logic        r_rdy, r_stl, r_jmp;
    logic [31:0] r_ja;
    logic        p_rdy, p_stl, p_jmp, p_req, p_valid;
    logic [31:0] p_ja, p_addr, p_iaddr, p_inst, exp_pc;
    int          n_del;

    initial begin
        rst_n = 1'b0; stallpc_i = 0; je_i = 0; jump_addr_i = 0; stallif_i = 0;
        flushif_i = 0; ibus_ready_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 0;

        // rdy stl | req addr vld iaddr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h00};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h14, 1'b0, 32'h00};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h1C};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h1C};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h1C};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h20};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 32'h28, 1'b0, 32'h00};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 32'h2C, 1'b1, 32'h24};

        repeat (2) @(negedge clk);
        #1;
        chk("reset req", 32'(ibus_req_o), 32'd0);
        chk("reset valid", 32'(inst_valid_o), 32'd0);
        chk("reset inst", inst_o, 32'h0000_0013);
        chk("reset inst_addr", inst_addr_o, 32'h0);
        @(negedge clk);

        // Streaming, ready back-pressure and stall-buffer sequence.
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rdy, tbl[i].stl, 1'b0, 1'b0, 32'h0, 0);
            chk_req($sformatf("tbl%0d", i), tbl[i].req, tbl[i].addr);
            chk_out($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].iaddr);
        end

        // Redirect while 0x40 is outstanding with a delayed response.
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2);
        chk_req("jmp issue40", 1'b1, 32'h40);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 0);
        chk("jmp req_in_je", 32'(s_req), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_req("jmp wait", 1'b0, 32'h0);
        chk_out("jmp flushed", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_req("jmp target", 1'b1, 32'h100);
        chk_out("jmp stale", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_out("jmp stale_dropped", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_out("jmp first", 1'b1, 32'h100);

        // Redirect + flush + stall together with a full buffer.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        chk("all3 stall req", 32'(s_req), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_out("all3 flushed", 1'b0, 32'h0);
        chk_req("all3 target", 1'b1, 32'h200);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1);
        chk_out("all3 first", 1'b1, 32'h200);
        chk_req("all3 next", 1'b1, 32'h208);

        // Reset with a request outstanding; its response returns during boot.
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk("async req", 32'(s_req), 32'd0);
        chk("async valid", 32'(s_valid), 32'd0);
        chk("async inst", s_inst, 32'h0000_0013);
        chk("async inst_addr", s_iaddr, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_req("rst boot", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_req("rst restart", 1'b1, 32'h0);
        chk_out("rst stale", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_out("rst pending", 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        chk_out("rst first", 1'b1, 32'h0);

        // Randomized run: deliveries must follow program order from each redirect.
        rst_n = 1'b0;
        m_act = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        n_del  = 0;
        p_rdy = 0; p_stl = 0; p_jmp = 0; p_ja = 0; p_req = 0; p_addr = 0;
        p_valid = 0; p_iaddr = 0; p_inst = 0;
        for (int i = 0; i < 2000; i++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_stl = ($urandom_range(0, 99) < 12);
            r_jmp = ($urandom_range(0, 99) < 5);
            r_ja  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                : 32'($urandom_range(0, 4095));
            step(r_rdy, r_stl, r_jmp, r_jmp, r_ja, $urandom_range(0, 2));

            if (s_req) chk("rnd addr_align", {30'h0, s_addr[1:0]}, 32'h0);
            if (p_req && !p_rdy && s_req) chk("rnd addr_stable", s_addr, p_addr);

            if (p_jmp) begin
                chk("rnd flush valid", 32'(s_valid), 32'd0);
            end else if (p_stl) begin
                chk("rnd hold valid", 32'(s_valid), 32'(p_valid));
                if (p_valid) chk("rnd hold addr", s_iaddr, p_iaddr);
            end else if (s_valid) begin
                chk("rnd stream addr", s_iaddr, exp_pc);
                chk("rnd stream inst", s_inst, exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            if (p_jmp) exp_pc = p_ja & ~32'd3;

            p_rdy = r_rdy; p_stl = r_stl; p_jmp = r_jmp; p_ja = r_ja;
            p_req = s_req; p_addr = s_addr; p_valid = s_valid; p_iaddr = s_iaddr; p_inst = s_inst;
        end
        chk("rnd progress", 32'(n_del >= 150), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
